// File: rtl/save_path_pkg.sv
// Shared constants and state encoding for the save-path buffer format
// "/Saves/camera/common/SRAM_NN.sav" followed by a 0x00 terminator.
package save_path_pkg;

    localparam int PATH_PREFIX_LENGTH = 26;
    localparam int PATH_SUFFIX_LENGTH = 4;
    localparam int PATH_DIGITS        = 2;
    localparam int PATH_TOTAL_LENGTH  = 32;

    localparam logic [7:0] ASCII_ZERO = 8'h30;

    localparam logic [7:0] PATH_PREFIX [PATH_PREFIX_LENGTH] = '{
        "/", "S", "a", "v", "e", "s", "/",
        "c", "a", "m", "e", "r", "a", "/",
        "c", "o", "m", "m", "o", "n", "/",
        "S", "R", "A", "M", "_"
    };

    localparam logic [7:0] PATH_SUFFIX [PATH_SUFFIX_LENGTH] = '{".", "s", "a", "v"};

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PREFIX,
        ST_TENS,
        ST_ONES,
        ST_SUFFIX,
        ST_TERM
    } state_t;

endpackage

// File: rtl/ascii_digit_pair_decode.sv
// Combinational decode of a stored tens digit plus an ASCII ones byte into
// a binary value; also flags whether the ones byte is an ASCII digit.
module ascii_digit_pair_decode
    import save_path_pkg::*;
(
    input  logic [3:0] i_tens,
    input  logic [7:0] i_ones,
    output logic       o_digit_ok,
    output logic [7:0] o_value
);

    logic [7:0] w_ones_bin;
    logic [7:0] w_tens8;

    assign w_ones_bin = i_ones - ASCII_ZERO;
    assign w_tens8    = {4'b0000, i_tens};
    assign o_digit_ok = (i_ones >= ASCII_ZERO) && (i_ones <= (ASCII_ZERO + 8'd9));

    // tens*10 as tens*8 + tens*2
    assign o_value = (w_tens8 << 3) + (w_tens8 << 1) + w_ones_bin;

endmodule

// File: rtl/save_path_reader.sv
// Walks the save-path buffer from address 0, checks the fixed path format
// and decodes the two-digit save slot index.
//
// state     | meaning
// ST_IDLE   | waiting for start; outputs held
// ST_PREFIX | comparing positions 0..25 against the fixed prefix
// ST_TENS   | position 26 must be a digit; tens stored
// ST_ONES   | position 27 must be a digit; index range-checked
// ST_SUFFIX | comparing positions 28..31 against ".sav"
// ST_TERM   | position 32 must be the 0x00 terminator
module save_path_reader
    import save_path_pkg::*;
#(
    parameter int MAX_INDEX = 99,
    parameter int MAX_LEN   = 256
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    output logic [7:0] address,
    input  logic [7:0] q,
    output logic       busy,
    output logic       done,
    output logic       valid,
    output logic [6:0] save_index
);

    state_t     r_state;
    state_t     w_next_state;
    logic [7:0] r_addr;
    logic [7:0] r_pos;
    logic       r_primed;
    logic [3:0] r_tens;
    logic [6:0] r_idx_pend;
    logic [6:0] r_save_index;
    logic       r_valid;
    logic       r_done;

    logic       w_accept;
    logic       w_sample;
    logic       w_fail;
    logic       w_pass;
    logic       w_digit_ok;
    logic [7:0] w_value;

    ascii_digit_pair_decode u_decode (
        .i_tens     (r_tens),
        .i_ones     (q),
        .o_digit_ok (w_digit_ok),
        .o_value    (w_value)
    );

    // done cycle is already IDLE, so it must be excluded explicitly
    assign w_accept = start && (r_state == ST_IDLE) && !r_done;
    // first busy cycle only presents address 0; q is not yet valid
    assign w_sample = r_primed && (r_state != ST_IDLE);

    always_comb begin
        w_next_state = r_state;
        w_fail       = 1'b0;
        w_pass       = 1'b0;
        if (r_state == ST_IDLE) begin
            if (w_accept) w_next_state = ST_PREFIX;
        end else if (w_sample) begin
            case (r_state)
                ST_PREFIX: begin
                    if (q != PATH_PREFIX[r_pos[4:0]]) w_fail = 1'b1;
                    else if (r_pos == 8'(PATH_PREFIX_LENGTH - 1)) w_next_state = ST_TENS;
                end
                ST_TENS: begin
                    if (!w_digit_ok) w_fail = 1'b1;
                    else             w_next_state = ST_ONES;
                end
                ST_ONES: begin
                    if (!w_digit_ok || (w_value > 8'(MAX_INDEX))) w_fail = 1'b1;
                    else                                          w_next_state = ST_SUFFIX;
                end
                ST_SUFFIX: begin
                    if (q != PATH_SUFFIX[r_pos[1:0]]) w_fail = 1'b1;
                    else if (r_pos == 8'(PATH_TOTAL_LENGTH - 1)) w_next_state = ST_TERM;
                end
                ST_TERM: begin
                    if (q == 8'h00) w_pass = 1'b1;
                    else            w_fail = 1'b1;
                end
                default: w_next_state = ST_IDLE;
            endcase
            if ((r_state != ST_TERM) && (r_pos == 8'(MAX_LEN - 1))) w_fail = 1'b1;
        end
        if (w_fail || w_pass) w_next_state = ST_IDLE;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= ST_IDLE;
            r_addr       <= 8'd0;
            r_pos        <= 8'd0;
            r_primed     <= 1'b0;
            r_tens       <= 4'd0;
            r_idx_pend   <= 7'd0;
            r_save_index <= 7'd0;
            r_valid      <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_done  <= w_fail || w_pass;
            if (w_accept) begin
                r_addr   <= 8'd0;
                r_pos    <= 8'd0;
                r_primed <= 1'b0;
                r_valid  <= 1'b0;
            end else if ((r_state != ST_IDLE) && !(w_fail || w_pass)) begin
                r_addr   <= r_addr + 8'd1;
                r_primed <= 1'b1;
                if (r_primed) r_pos <= r_pos + 8'd1;
            end
            if (w_sample && (r_state == ST_TENS)) r_tens     <= q[3:0];
            if (w_sample && (r_state == ST_ONES)) r_idx_pend <= w_value[6:0];
            if (w_pass) begin
                r_valid      <= 1'b1;
                r_save_index <= r_idx_pend;
            end
        end
    end

    assign address    = r_addr;
    assign busy       = (r_state != ST_IDLE);
    assign done       = r_done;
    assign valid      = r_valid;
    assign save_index = r_save_index;

endmodule

// File: doc/save_path_reader.md
Name: save_path_reader

Overview:
- Initiator-side parser for the save-path buffer that the bridge/APF side fills and the camera core reads back.
- On a start pulse it walks a byte-addressed, 1-cycle-latency read port from address 0.
- It checks the string against the fixed save-path format "/Saves/camera/common/SRAM_NN.sav" followed by a 0x00 terminator.
- It decodes the two ASCII digits NN to a binary save index, so the core can resume from, or select, the save slot named by the host.

Parameters:
- MAX_INDEX, 99: highest accepted save index. A decoded index above this value is a format failure.
- MAX_LEN, 256: address-space size of the path buffer. Reaching the last address without a terminator is a failure.

Ports:
- clk  in  1  core clock
- reset_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; begins a parse (ignored while busy)
- address  out  8  read address to the path buffer
- q  in  8  buffer read data; valid one cycle after address is presented
- busy  out  1  high from the cycle after an accepted start until the cycle done pulses
- done  out  1  one-cycle completion pulse
- valid  out  1  path matched format; held until the next accepted start
- save_index  out  7  decoded binary index; held; meaningful only when valid=1

Behaviour:
- Reset (asynchronous, reset_n=0): address=0, busy=0, done=0, valid=0, save_index=0, state=IDLE. Reset mid-parse aborts the parse with no done pulse.
- Throughput: one byte per cycle. Let the accepted start be at cycle S.
  - Position p is driven on address at S+1+p.
  - q for position p is sampled at S+2+p.
  - The same cycle start is accepted, valid is cleared to 0.
- Read pipeline:
  - The address counter runs one ahead of the sample-position counter.
  - The read in flight when the parse ends is discarded.
  - After completion, address holds its last value.
- States: IDLE -> PREFIX -> TENS -> ONES -> SUFFIX -> TERM -> IDLE.
  - PREFIX: positions 0..25 must equal the prefix bytes exactly (case-sensitive).
  - TENS: position 26 must be "0".."9". Store (q-0x30).
  - ONES: position 27 must be "0".."9". Compute index = tens*10 + ones as an 8-bit intermediate (max 99), then compare against MAX_INDEX.
  - SUFFIX: positions 28..31 must equal ".sav".
  - TERM: position 32 must be 0x00.
- Success: at sample S+34, done pulses at S+35. In the same cycle valid=1, busy=0, and save_index=index[6:0].
- Failure: any mismatch sampled at position p, including a premature 0x00, a non-digit, or index>MAX_INDEX.
  - done pulses at S+3+p with valid=0 and busy=0.
  - save_index keeps its previous value.
- Length guard: if the sample position would exceed MAX_LEN-1, fail. This is unreachable with the fixed 33-byte format, but it is still required.
- start while busy: ignored; the parse continues unchanged.
- start in the same cycle done pulses: ignored. A start is accepted only in IDLE with busy=0.
- Back-to-back parses: start may be accepted the cycle after done.

Decomposition:
- Shared package save_path_pkg, shared with the path generator:
  - PATH_PREFIX_LENGTH=26, PATH_SUFFIX_LENGTH=4, PATH_DIGITS=2, PATH_TOTAL_LENGTH=32
  - the prefix and suffix byte constant arrays
  - the ASCII_ZERO constant
  - the state enum typedef
- One sub-module: ascii_digit_pair_decode.
  - Combinational.
  - Takes a tens nibble and an ASCII ones byte.
  - Returns digit_ok and an 8-bit binary value.
  - Keeps the multiply-by-10 (shift-add) out of the FSM.

Test Plan:
- Buffer "/Saves/camera/common/SRAM_07.sav\0", start at S:
  - address sequence 0..32 on cycles S+1..S+33
  - done at S+35, valid=1, save_index=7, busy high S+1..S+34
- Buffer with "_99", MAX_INDEX=99: valid=1, save_index=99.
- Same buffer, MAX_INDEX=15, digits "16": done at S+30, valid=0, save_index unchanged.
- Position 1 is "s" (lowercase): done at S+4, valid=0. Address stops advancing after S+4.
- Digits "A3": fail at position 26, done at S+29, valid=0.
- Position 32 is "x" instead of 0x00: done at S+35, valid=0. Then a valid "_42" parse started the next cycle gives save_index=42.
- start pulsed at S+10 during a parse: no effect; done still at S+35.
- reset_n low at S+15 for 1 cycle:
  - all outputs 0, no done pulse
  - a new start then parses normally
